// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit for the execute stage.
// Multiply uses radix-2 Booth recoding, divide uses restoring shift-subtract
// on magnitudes; both share one 65-bit working register and take 32 cycles.
module multdiv_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [64:0] acc_q, acc_d;
  logic        booth_q, booth_d;
  logic [31:0] opnd_q, opnd_d;
  logic        negQ_q, negQ_d;
  logic        divOvf_q, divOvf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        busy_q, busy_d;
  logic        rdy_q, rdy_d;

  logic [32:0] boothHi, boothSum;
  logic [64:0] mulNext;
  logic        mulOvf;
  logic [32:0] divShift, divTrial;
  logic [64:0] divNext;
  logic [31:0] quotient;
  logic [31:0] magA, magB;

  // The upper half is kept 33 bits wide so adding/subtracting the most
  // negative multiplicand can never wrap before the arithmetic shift.
  assign boothHi = acc_q[64:32];

  // Booth recoding of the current multiplier bit pair picks add, subtract or nothing.
  always_comb begin
    boothSum = boothHi;
    case ({acc_q[0], booth_q})
      2'b01:   boothSum = boothHi + {opnd_q[31], opnd_q};
      2'b10:   boothSum = boothHi - {opnd_q[31], opnd_q};
      default: boothSum = boothHi;
    endcase
  end

  assign mulNext = {boothSum[32], boothSum, acc_q[31:1]};
  assign mulOvf  = !((&mulNext[63:31]) || !(|mulNext[63:31]));

  // Remainder lives in the upper part, dividend/quotient bits in the lower 32.
  assign divShift = {acc_q[63:32], acc_q[31]};
  assign divTrial = divShift - {1'b0, opnd_q};
  assign divNext  = divTrial[32] ? {divShift, acc_q[30:0], 1'b0}
                                 : {divTrial, acc_q[30:0], 1'b1};
  assign quotient = negQ_q ? (32'd0 - divNext[31:0]) : divNext[31:0];

  assign magA = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
  assign magB = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

  // Next-state logic: start acceptance, one iteration per cycle, completion.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    booth_d  = booth_q;
    opnd_d   = opnd_q;
    negQ_d   = negQ_q;
    divOvf_d = divOvf_q;
    result_d = result_q;
    exc_d    = exc_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (ctrl_MULT) begin
          state_d = MUL;
          count_d = 5'd0;
          opnd_d  = data_operandA;
          acc_d   = {33'd0, data_operandB};
          booth_d = 1'b0;
        end else if (ctrl_DIV) begin
          state_d  = DIV;
          count_d  = 5'd0;
          opnd_d   = magB;
          acc_d    = {33'd0, magA};
          negQ_d   = data_operandA[31] ^ data_operandB[31];
          divOvf_d = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
        end
      end
      MUL: begin
        acc_d   = mulNext;
        booth_d = acc_q[0];
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d  = DONE;
          result_d = mulNext[31:0];
          exc_d    = mulOvf;
        end
      end
      DIV: begin
        if (opnd_q == 32'd0) begin
          state_d  = DONE;
          count_d  = 5'd0;
          result_d = 32'd0;
          exc_d    = 1'b1;
        end else begin
          acc_d   = divNext;
          count_d = count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_d  = DONE;
            result_d = quotient;
            exc_d    = divOvf_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == MUL) || (state_d == DIV);
    rdy_d  = (state_d == DONE);
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= 5'd0;
      acc_q    <= 65'd0;
      booth_q  <= 1'b0;
      opnd_q   <= 32'd0;
      negQ_q   <= 1'b0;
      divOvf_q <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      acc_q    <= acc_d;
      booth_q  <= booth_d;
      opnd_q   <= opnd_d;
      negQ_q   <= negQ_d;
      divOvf_q <= divOvf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed cases plus randomized operations
// compared against plain 64-bit arithmetic.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int          checks;
  int          failures;
  logic [31:0] lastRes;

  multdiv_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Free-running clock, 10 time units per cycle.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference: exact signed product/quotient, flag set when it does not fit 32 bits.
  task automatic modelOp(input logic isMul, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
    longint full;
    if (isMul) begin
      full = longint'($signed(a)) * longint'($signed(b));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
      return;
    end else begin
      full = longint'($signed(a)) / longint'($signed(b));
    end
    res = full[31:0];
    exc = (full != longint'($signed(res)));
  endtask

  // Called at a falling edge; presents a start and lets the next rising edge take it.
  task automatic applyStimulus(input logic mul, input logic div, input logic [31:0] a,
                               input logic [31:0] b, input logic hold);
    ctrl_MULT     = mul;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    if (!hold) begin
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
    end
  endtask

  // Waits (bounded) for the completion pulse after a start edge and checks it.
  task automatic waitDone(input string tag, input int expLatency, input logic [31:0] expRes,
                          input logic expExc, input logic disturb);
    int   n;
    logic busyOk;
    logic holdOk;
    n      = 0;
    busyOk = 1'b1;
    holdOk = 1'b1;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (data_resultRDY === 1'b1) break;
      if (busy !== 1'b1) busyOk = 1'b0;
      if (data_result !== lastRes) holdOk = 1'b0;
      if (disturb) begin
        if (n == 2) begin
          data_operandA = $urandom;
          data_operandB = $urandom;
        end
        if (n == 10) ctrl_DIV = 1'b1;
        if (n == 11) ctrl_DIV = 1'b0;
        if (n == 21) ctrl_MULT = 1'b0;
      end
    end
    checkOutput({tag, " rdy"}, 64'(data_resultRDY), 64'd1);
    checkOutput({tag, " latency"}, 64'(n), 64'(expLatency));
    checkOutput({tag, " result"}, 64'(data_result), 64'(expRes));
    checkOutput({tag, " exception"}, 64'(data_exception), 64'(expExc));
    checkOutput({tag, " busy while running"}, 64'(busyOk), 64'd1);
    checkOutput({tag, " busy low at rdy"}, 64'(busy), 64'd0);
    checkOutput({tag, " result held"}, 64'(holdOk), 64'd1);
    lastRes = expRes;
  endtask

  // One cycle after the pulse the unit should be idle again.
  task automatic finishPulse(input string tag);
    @(negedge clock);
    checkOutput({tag, " rdy one cycle"}, 64'(data_resultRDY), 64'd0);
    checkOutput({tag, " busy idle"}, 64'(busy), 64'd0);
    checkOutput({tag, " result after"}, 64'(data_result), 64'(lastRes));
  endtask

  task automatic runOp(input string tag, input logic mul, input logic div,
                       input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          lat;
    modelOp(mul, a, b, r, e);
    lat = (!mul && b == 32'd0) ? 2 : 33;
    applyStimulus(mul, div, a, b, 1'b0);
    waitDone(tag, lat, r, e, 1'b0);
    finishPulse(tag);
  endtask

  initial begin
    logic [31:0] r;
    logic        e;
    logic        sawRdy;
    checks        = 0;
    failures      = 0;
    lastRes       = 32'd0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    reset         = 1'b1;
    #2 reset = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("reset result", 64'(data_result), 64'd0);
    checkOutput("reset exception", 64'(data_exception), 64'd0);
    checkOutput("reset rdy", 64'(data_resultRDY), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    runOp("mul 7*-3", 1'b1, 1'b0, 32'h0000_0007, 32'hFFFF_FFFD);
    runOp("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    runOp("div -7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'h0000_0002);
    runOp("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7);
    runOp("div 5/0", 1'b0, 1'b1, 32'd5, 32'd0);
    runOp("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("mul min*min", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);

    // Starts during an operation must not restart it or re-latch operands.
    modelOp(1'b1, 32'h0000_1234, 32'hFFFF_FF00, r, e);
    applyStimulus(1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FF00, 1'b1);
    waitDone("ignored starts", 33, r, e, 1'b1);
    finishPulse("ignored starts");

    runOp("both starts", 1'b1, 1'b1, 32'd9, 32'd11);

    // Back-to-back: divide issued during the multiply's completion cycle.
    applyStimulus(1'b1, 1'b0, 32'd6, 32'd7, 1'b0);
    waitDone("b2b mul", 33, 32'h2A, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd84, 32'd2, 1'b0);
    waitDone("b2b div", 33, 32'h2A, 1'b0, 1'b0);
    finishPulse("b2b div");

    // Reset in the middle of a divide clears everything and suppresses completion.
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd3, 1'b0);
    repeat (12) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("midreset result", 64'(data_result), 64'd0);
    checkOutput("midreset exception", 64'(data_exception), 64'd0);
    checkOutput("midreset rdy", 64'(data_resultRDY), 64'd0);
    checkOutput("midreset busy", 64'(busy), 64'd0);
    lastRes = 32'd0;
    repeat (3) @(negedge clock);
    reset  = 1'b1;
    sawRdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0) sawRdy = 1'b1;
    end
    checkOutput("midreset no rdy", 64'(sawRdy), 64'd0);
    runOp("mul 3*4", 1'b1, 1'b0, 32'd3, 32'd4);

    // Randomized operations with a bias toward the interesting corners.
    for (int k = 0; k < 24; k++) begin
      logic        isMul;
      logic        both;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      isMul = 1'($urandom_range(0, 1));
      both  = 1'b0;
      a     = $urandom;
      b     = $urandom;
      sel   = int'($urandom_range(0, 7));
      case (sel)
        0: b = 32'd0;
        1: begin
          a = 32'($urandom_range(0, 200)) - 32'd100;
          b = 32'($urandom_range(0, 20)) - 32'd10;
        end
        2: begin
          a = 32'h8000_0000;
          b = 32'hFFFF_FFFF;
        end
        3: b = 32'($urandom_range(0, 64)) - 32'd32;
        4: both = 1'b1;
        default: ;
      endcase
      runOp($sformatf("rand%0d", k), isMul | both, ~isMul | both, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
